// File: rtl/mig_eval_pkg.sv
// Shared types and helpers for the majority-inverter-graph truth-table engine.
// Widths here match the engine's default NUM_INPUTS/MAX_NODES parameters.
package mig_eval_pkg;

  localparam int MIG_NUM_INPUTS = 7;
  localparam int MIG_MAX_NODES  = 16;
  localparam int MIG_SIG_W      = $clog2(1 + MIG_NUM_INPUTS + MIG_MAX_NODES);
  localparam int MIG_ADDR_W     = $clog2(MIG_MAX_NODES);

  localparam int SIG_CONST0 = 0;

  typedef struct packed {
    logic [MIG_SIG_W-1:0] sel_a;
    logic [MIG_SIG_W-1:0] sel_b;
    logic [MIG_SIG_W-1:0] sel_c;
    logic [2:0]           inv;
  } node_desc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Node k lives just above the constant and the primary inputs.
  function automatic logic [MIG_SIG_W-1:0] sig_idx_of_node(input logic [MIG_ADDR_W-1:0] k);
    return MIG_SIG_W'(1 + MIG_NUM_INPUTS) + MIG_SIG_W'(k);
  endfunction

endpackage

// File: rtl/mig_truth_table_engine_maj3_sel.sv
// Operand select, optional complement and 3-input majority for one MIG node.
// Operands at or above limit_i are forward/out-of-range references: read as 0, flagged.
module maj3_sel #(
  parameter int NSIG  = 24,
  parameter int SIG_W = 5
) (
  input  logic [NSIG-1:0]  sig_i,
  input  logic [SIG_W-1:0] sel_a_i,
  input  logic [SIG_W-1:0] sel_b_i,
  input  logic [SIG_W-1:0] sel_c_i,
  input  logic [2:0]       inv_i,
  input  logic [SIG_W-1:0] limit_i,
  output logic             maj_o,
  output logic             illegal_o
);

  logic ok_a, ok_b, ok_c;
  logic op_a, op_b, op_c;

  always_comb begin
    ok_a = (sel_a_i < limit_i);
    ok_b = (sel_b_i < limit_i);
    ok_c = (sel_c_i < limit_i);
    op_a = (ok_a ? sig_i[sel_a_i] : 1'b0) ^ inv_i[0];
    op_b = (ok_b ? sig_i[sel_b_i] : 1'b0) ^ inv_i[1];
    op_c = (ok_c ? sig_i[sel_c_i] : 1'b0) ^ inv_i[2];
    maj_o     = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    illegal_o = ~(ok_a & ok_b & ok_c);
  end

endmodule

// File: rtl/mig_truth_table_engine.sv
// Programmable MIG evaluator: sweeps every minterm, one node per cycle, and
// assembles the full truth table of the selected output signal.
module mig_truth_table_engine
  import mig_eval_pkg::*;
#(
  parameter int NUM_INPUTS = MIG_NUM_INPUTS,
  parameter int MAX_NODES  = MIG_MAX_NODES,
  parameter int SIG_W      = $clog2(1 + NUM_INPUTS + MAX_NODES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [$clog2(MAX_NODES)-1:0]   cfg_addr,
  input  logic [3*SIG_W-1:0]             cfg_sel,
  input  logic [2:0]                     cfg_inv,
  input  logic [$clog2(MAX_NODES+1)-1:0] cfg_num_nodes,
  input  logic [SIG_W-1:0]               cfg_out_sel,
  input  logic                           cfg_out_inv,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [2**NUM_INPUTS-1:0]       tt,
  output logic                           err,
  output logic [1:0]                     dbg_state
);

  localparam int TT_W = 2 ** NUM_INPUTS;
  localparam int NSIG = 1 + NUM_INPUTS + MAX_NODES;
  localparam int AW   = $clog2(MAX_NODES);
  localparam int NW   = $clog2(MAX_NODES + 1);
  localparam int MW   = NUM_INPUTS + 1;

  state_e                 state_q;
  node_desc_t             ram_q [MAX_NODES];
  logic [NW-1:0]          n_q;
  logic [SIG_W-1:0]       out_sel_q;
  logic                   out_inv_q;
  logic [MW-1:0]          m_q;
  logic [AW-1:0]          k_q;
  logic [MAX_NODES-1:0]   node_val_q;
  logic [TT_W-1:0]        tt_q;
  logic                   busy_q, done_q, err_q;

  node_desc_t             cur_desc;
  logic [NSIG-1:0]        sig_vec;
  logic [SIG_W-1:0]       node_limit;
  logic [SIG_W-1:0]       out_limit;
  logic [NW-1:0]          n_clamped;
  logic                   maj, op_illegal;
  logic                   last_node, out_illegal, out_bypass, out_bit_d;

  // Signal space: constant 0, then x0..x(n-1) from the minterm, then node values.
  always_comb begin
    sig_vec                           = '0;
    sig_vec[SIG_CONST0]               = 1'b0;
    sig_vec[NUM_INPUTS:1]             = m_q[NUM_INPUTS-1:0];
    sig_vec[NSIG-1:NUM_INPUTS+1]      = node_val_q;
  end

  assign cur_desc   = ram_q[k_q];
  assign node_limit = sig_idx_of_node(k_q);

  maj3_sel #(
    .NSIG  (NSIG),
    .SIG_W (SIG_W)
  ) u_maj3_sel (
    .sig_i     (sig_vec),
    .sel_a_i   (cur_desc.sel_a),
    .sel_b_i   (cur_desc.sel_b),
    .sel_c_i   (cur_desc.sel_c),
    .inv_i     (cur_desc.inv),
    .limit_i   (node_limit),
    .maj_o     (maj),
    .illegal_o (op_illegal)
  );

  // The output may name the node being evaluated right now, so bypass its fresh value.
  always_comb begin
    n_clamped   = (cfg_num_nodes > NW'(MAX_NODES)) ? NW'(MAX_NODES) : cfg_num_nodes;
    last_node   = (n_q == '0) || (NW'(k_q) == n_q - NW'(1));
    out_limit   = SIG_W'(1 + NUM_INPUTS) + SIG_W'(n_q);
    out_illegal = (out_sel_q >= out_limit);
    out_bypass  = (n_q != '0) && (out_sel_q == node_limit);
    if (out_illegal) begin
      out_bit_d = out_inv_q;
    end else if (out_bypass) begin
      out_bit_d = maj ^ out_inv_q;
    end else begin
      out_bit_d = sig_vec[out_sel_q] ^ out_inv_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NODES; i++) ram_q[i] <= '0;
    end else if (cfg_we && !busy_q) begin
      ram_q[cfg_addr] <= '{sel_a: cfg_sel[SIG_W-1:0],
                           sel_b: cfg_sel[2*SIG_W-1:SIG_W],
                           sel_c: cfg_sel[3*SIG_W-1:2*SIG_W],
                           inv:   cfg_inv};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      out_sel_q  <= '0;
      out_inv_q  <= 1'b0;
      m_q        <= '0;
      k_q        <= '0;
      node_val_q <= '0;
      tt_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q       <= n_clamped;
            out_sel_q <= cfg_out_sel;
            out_inv_q <= cfg_out_inv;
            err_q     <= 1'b0;
            tt_q      <= '0;
            m_q       <= '0;
            k_q       <= '0;
            busy_q    <= 1'b1;
            state_q   <= EVAL;
          end
        end
        EVAL: begin
          if (n_q != '0) begin
            node_val_q[k_q] <= maj;
            if (op_illegal) err_q <= 1'b1;
          end
          if (last_node) begin
            tt_q[m_q[NUM_INPUTS-1:0]] <= out_bit_d;
            if (out_illegal) err_q <= 1'b1;
            k_q <= '0;
            m_q <= m_q + MW'(1);
            if (m_q == MW'(TT_W - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tt        = tt_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mig_truth_table_engine.sv
// Bench for mig_truth_table_engine: directed and random networks scored
// against a minterm-by-minterm reference evaluator.
module tb_mig_truth_table_engine;

  localparam int NI   = 7;
  localparam int MAXN = 16;
  localparam int SW   = 5;
  localparam int TTW  = 128;
  localparam logic [127:0] REF_TT = 128'hfeeaeee0fce8e8c0fce8e8c0f888a880;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [3*SW-1:0]  cfg_sel;
  logic [2:0]       cfg_inv;
  logic [4:0]       cfg_num_nodes;
  logic [SW-1:0]    cfg_out_sel;
  logic             cfg_out_inv;
  logic             start;
  logic             busy, done, err;
  logic [TTW-1:0]   tt;
  logic [1:0]       dbg_state;

  mig_truth_table_engine dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .cfg_inv(cfg_inv), .cfg_num_nodes(cfg_num_nodes),
    .cfg_out_sel(cfg_out_sel), .cfg_out_inv(cfg_out_inv), .start(start),
    .busy(busy), .done(done), .tt(tt), .err(err), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // descriptor model
  int md_a [MAXN], md_b [MAXN], md_c [MAXN], md_inv [MAXN];

  task automatic clear_model();
    for (int i = 0; i < MAXN; i++) begin
      md_a[i] = 0; md_b[i] = 0; md_c[i] = 0; md_inv[i] = 0;
    end
  endtask

  // Straight evaluation of the network for every minterm.
  task automatic model(input int n, input int osel, input int oinv,
                       output logic [127:0] exp_tt, output logic exp_err);
    int s [1+NI+MAXN];
    int ops [3];
    int inv, cnt;
    exp_tt  = '0;
    exp_err = 1'b0;
    for (int m = 0; m < TTW; m++) begin
      for (int i = 0; i < 1+NI+MAXN; i++) s[i] = 0;
      for (int i = 0; i < NI; i++) s[1+i] = (m >> i) & 1;
      for (int k = 0; k < n; k++) begin
        ops[0] = md_a[k]; ops[1] = md_b[k]; ops[2] = md_c[k];
        inv = md_inv[k];
        cnt = 0;
        for (int j = 0; j < 3; j++) begin
          int v;
          if (ops[j] < 1 + NI + k) v = s[ops[j]];
          else begin v = 0; exp_err = 1'b1; end
          cnt += v ^ ((inv >> j) & 1);
        end
        s[1+NI+k] = (cnt >= 2) ? 1 : 0;
      end
      if (osel < 1 + NI + n) exp_tt[m] = 1'(s[osel] ^ oinv);
      else begin exp_tt[m] = 1'(oinv); exp_err = 1'b1; end
    end
  endtask

  // scoreboard
  logic [127:0] exp_tt_q  [$];
  logic [0:0]   exp_err_q [$];
  logic [31:0]  exp_lat_q [$];
  int start_cyc  = 0;
  int done_count = 0;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_tt_q.size() == 0) begin
        check("unexpected_done", 128'd1, 128'd0);
      end else begin
        logic [127:0] e_tt;
        logic [0:0]   e_err;
        logic [31:0]  e_lat;
        e_tt  = exp_tt_q.pop_front();
        e_err = exp_err_q.pop_front();
        e_lat = exp_lat_q.pop_front();
        check("tt", tt, e_tt);
        check("err", 128'(err), 128'(e_err));
        check("latency", 128'(cyc - start_cyc), 128'(e_lat));
        check("busy_at_done", 128'(busy), 128'd0);
      end
      done_count++;
    end
  end

  // drivers
  task automatic write_node(input int k, input int a, input int b, input int c,
                            input int inv, input bit update_model);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 4'(k);
    cfg_sel  = {SW'(c), SW'(b), SW'(a)};
    cfg_inv  = 3'(inv);
    if (update_model) begin
      md_a[k] = a; md_b[k] = b; md_c[k] = c; md_inv[k] = inv;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_eval(input int n, input int osel, input int oinv,
                            input bit use_golden, input logic [127:0] golden);
    logic [127:0] m_tt;
    logic         m_err;
    model(n, osel, oinv, m_tt, m_err);
    exp_tt_q.push_back(use_golden ? golden : m_tt);
    exp_err_q.push_back(use_golden ? 1'b0 : m_err);
    exp_lat_q.push_back(32'(TTW * ((n == 0) ? 1 : n) + 1));
    @(negedge clk);
    cfg_num_nodes = 5'(n);
    cfg_out_sel   = SW'(osel);
    cfg_out_inv   = 1'(oinv);
    start         = 1'b1;
    start_cyc     = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
  endtask

  task automatic wait_done();
    int seen, t;
    seen = done_count;
    t = 0;
    while (done_count == seen && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_count == seen) begin
      check("done_timeout", 128'd0, 128'd1);
      exp_tt_q.delete(); exp_err_q.delete(); exp_lat_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic load_ref();
    write_node(0, 2, 3, 5, 0, 1);
    write_node(1, 6, 7, 8, 0, 1);
    write_node(2, 1, 2, 9, 0, 1);
    write_node(3, 3, 5, 10, 0, 1);
    write_node(4, 1, 3, 11, 0, 1);
    write_node(5, 4, 10, 12, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_sel = 0; cfg_inv = 0;
    cfg_num_nodes = 0; cfg_out_sel = 0; cfg_out_inv = 0; start = 0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_tt", tt, 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    rst_n = 1'b1;

    // reference network
    load_ref();
    start_eval(6, 13, 0, 1, REF_TT);
    wait_done();

    // N=0: output is ~x0
    start_eval(0, 1, 1, 1, {32{4'h5}});
    wait_done();

    // N=1: node0 = MAJ(x0, x1, ~0) = OR
    write_node(0, 1, 2, 0, 4, 1);
    start_eval(1, 8, 0, 1, {32{4'he}});
    wait_done();

    // forward reference: node0 reads node1
    write_node(0, 9, 2, 3, 0, 1);
    write_node(1, 1, 8, 4, 0, 1);
    start_eval(2, 9, 0, 0, '0);
    wait_done();
    check("err_sticky_after_done", 128'(err), 128'd1);

    // random networks, occasional illegal references
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) begin
        int sel [3];
        for (int j = 0; j < 3; j++)
          sel[j] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 23) : $urandom_range(0, 7 + k);
        write_node(k, sel[0], sel[1], sel[2], $urandom_range(0, 7), 1);
      end
      start_eval(n, $urandom_range(0, 8 + n), $urandom_range(0, 1), 0, '0);
      wait_done();
    end

    // cfg_we and start during EVAL are ignored
    load_ref();
    start_eval(6, 13, 0, 1, REF_TT);
    repeat (100) @(negedge clk);
    start = 1'b1;
    write_node(5, 1, 1, 1, 7, 0);
    start = 1'b0;
    wait_done();

    // asynchronous reset near minterm 40
    start_eval(6, 13, 0, 1, REF_TT);
    repeat (40 * 6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_tt", tt, 128'd0);
    check("midrst_err", 128'(err), 128'd0);
    exp_tt_q.delete(); exp_err_q.delete(); exp_lat_q.delete();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;

    // cleared RAM: node0 = MAJ(0,0,0), inverted at the output -> all ones
    start_eval(1, 8, 1, 0, '0);
    wait_done();
    load_ref();
    start_eval(6, 13, 0, 1, REF_TT);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
